dmem_responder: RTL and testbench

- Data-memory target that serves the pipelined core's dmem initiator port (dmem_addr/wdata/we/be/size → dmem_rdata).
- Holds a DEPTH_WORDS x 32 word array addressed by the word offset the core already produces (DMEM_BASE_ADDR subtracted, low 2 bits zero).
- Provides combinational reads and synchronous byte-lane writes, with lane realignment of unshifted store data.
- Includes a post-reset zero-fill state machine and a sticky malformed-access error flag.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 22 ++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM state
// type and the byte-enable legality rule for core stores.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_t;

    // A store is well formed only when its lane mask matches its size code:
    // a word covers all lanes, a half covers one aligned lane pair and a
    // byte covers exactly one lane. Size code 11 never forms a valid store.
    function automatic logic be_legal(input logic [1:0] size, input logic [3:0] be);
        logic ok;
        case (size)
            SIZE_WORD: ok = (be == 4'b1111);
            SIZE_HALF: ok = (be == 4'b0011) || (be == 4'b1100);
            SIZE_BYTE: ok = (be == 4'b0001) || (be == 4'b0010) ||
                            (be == 4'b0100) || (be == 4'b1000);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Replicates unshifted store data onto the byte lanes it may land in, so the
// byte enables alone decide which lanes of the word are updated.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] lane_data
);

    // Spread the low byte/half across the word according to the access size.
    always_comb begin
        lane_data = wdata;
        case (size)
            SIZE_WORD: lane_data = wdata;
            SIZE_HALF: lane_data = {wdata[15:0], wdata[15:0]};
            SIZE_BYTE: lane_data = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
            default:   lane_data = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core's dmem port. Reads are combinational,
// stores are byte-lane synchronous writes. After reset the array is swept to
// zero one word per cycle before core accesses are honoured; malformed
// stores are dropped and latch a sticky error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_we,
    input  logic [3:0]  dmem_be,
    input  logic [1:0]  dmem_size,
    output logic [31:0] dmem_rdata,
    output logic        init_done,
    input  logic        err_clr,
    output logic        misalign_err,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_rdata
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    logic [31:0]      mem_q [DEPTH_WORDS];

    dmem_state_t      state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             init_done_q, init_done_d;
    logic             misalign_err_q, misalign_err_d;

    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] dbg_idx_s;
    logic             wr_legal_s;
    logic [31:0]      lane_data_s;
    logic             mem_we_s;
    logic [IDX_W-1:0] mem_idx_s;
    logic [31:0]      mem_wdata_s;
    logic [3:0]       mem_be_s;
    logic             unused_addr_bits_s;

    // Byte offsets wrap inside the window: only the word-index bits matter.
    assign idx_s     = dmem_addr[IDX_W+1:2];
    assign dbg_idx_s = dbg_addr[IDX_W+1:2];
    assign unused_addr_bits_s = ^{dmem_addr[31:IDX_W+2], dmem_addr[1:0],
                                  dbg_addr[31:IDX_W+2], dbg_addr[1:0]};

    assign wr_legal_s = be_legal(dmem_size, dmem_be);

    dmem_lane_align u_lane_align (
        .size      (dmem_size),
        .wdata     (dmem_wdata),
        .lane_data (lane_data_s)
    );

    // Next-state logic: zero-fill sweep, then steady READY with sticky error.
    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        init_done_d    = init_done_q;
        misalign_err_d = misalign_err_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + ONE_IDX;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d     = READY;
                    init_done_d = 1'b1;
                end else begin
                    state_d     = CLEAR;
                    init_done_d = 1'b0;
                end
            end
            READY: begin
                state_d     = READY;
                init_done_d = 1'b1;
                // A new malformed store wins over a simultaneous clear.
                if (dmem_we && !wr_legal_s) begin
                    misalign_err_d = 1'b1;
                end else if (err_clr) begin
                    misalign_err_d = 1'b0;
                end else begin
                    misalign_err_d = misalign_err_q;
                end
            end
            default: begin
                state_d        = CLEAR;
                clr_cnt_d      = {IDX_W{1'b0}};
                init_done_d    = 1'b0;
                misalign_err_d = 1'b0;
            end
        endcase
    end

    // Single array write port shared by the zero-fill sweep and core stores.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_idx_s   = clr_cnt_q;
        mem_wdata_s = 32'h0000_0000;
        mem_be_s    = 4'b0000;
        case (state_q)
            CLEAR: begin
                mem_we_s    = 1'b1;
                mem_idx_s   = clr_cnt_q;
                mem_wdata_s = 32'h0000_0000;
                mem_be_s    = 4'b1111;
            end
            READY: begin
                if (dmem_we && wr_legal_s) begin
                    mem_we_s    = 1'b1;
                    mem_idx_s   = idx_s;
                    mem_wdata_s = lane_data_s;
                    mem_be_s    = dmem_be;
                end else begin
                    mem_we_s    = 1'b0;
                    mem_idx_s   = idx_s;
                    mem_wdata_s = 32'h0000_0000;
                    mem_be_s    = 4'b0000;
                end
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Control registers; reset restarts the sweep from word 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= CLEAR;
            clr_cnt_q      <= {IDX_W{1'b0}};
            init_done_q    <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            init_done_q    <= init_done_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // Storage array: no reset of its own, only lane-masked writes.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be_s[i]) begin
                    mem_q[mem_idx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Core read path is blanked until the sweep has finished.
    always_comb begin
        dmem_rdata = 32'h0000_0000;
        if (state_q == READY) begin
            dmem_rdata = mem_q[idx_s];
        end else begin
            dmem_rdata = 32'h0000_0000;
        end
    end

    assign dbg_rdata    = mem_q[dbg_idx_s];
    assign init_done    = init_done_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: zero-fill timing, directed store vectors, random
// traffic against a byte-level reference model, and reset during the sweep.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [1:0]  dmem_size;
    logic [31:0] dmem_rdata;
    logic        init_done;
    logic        err_clr;
    logic        misalign_err;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_we      (dmem_we),
        .dmem_be      (dmem_be),
        .dmem_size    (dmem_size),
        .dmem_rdata   (dmem_rdata),
        .init_done    (init_done),
        .err_clr      (err_clr),
        .misalign_err (misalign_err),
        .dbg_addr     (dbg_addr),
        .dbg_rdata    (dbg_rdata)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        clr;
        logic [31:0] exp_old;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [14];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [1024];
    logic        model_err;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [1:0] size, input logic [3:0] be);
        case (size)
            2'd0:    return $countones(be) == 1;
            2'd1:    return (be == 4'd3) || (be == 4'd12);
            2'd2:    return be == 4'd15;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: each enabled byte of the target word takes the store byte
    // that belongs at that byte position for the given access size.
    task automatic model_step(input logic we, input logic [1:0] size, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic clr);
        int idx;
        logic [31:0] b;
        idx = int'(addr[11:2]);
        if (we && ref_legal(size, be)) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    if (size == 2'd2)      b = wdata >> (8 * i);
                    else if (size == 2'd1) b = wdata >> (8 * (i % 2));
                    else                   b = wdata;
                    model_mem[idx][8*i +: 8] = b[7:0];
                end
            end
        end
        if (we && !ref_legal(size, be)) model_err = 1'b1;
        else if (clr)                   model_err = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic clr);
        dmem_we    = we;
        dmem_size  = size;
        dmem_be    = be;
        dmem_addr  = addr;
        dmem_wdata = wdata;
        err_clr    = clr;
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (init_done !== 1'b1 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
        model_err = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [1:0]  r_size;
        logic [3:0]  r_be;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic        r_we;
        logic        r_clr;

        vecs[0]  = '{1'b1, 2'b00, 4'b0010, 32'h005,  32'h0000_00AB, 1'b0, 32'h0,         32'h0000_AB00, 1'b0};
        vecs[1]  = '{1'b1, 2'b10, 4'b1111, 32'h010,  32'h1122_3344, 1'b0, 32'h0,         32'h1122_3344, 1'b0};
        vecs[2]  = '{1'b1, 2'b01, 4'b1100, 32'h012,  32'h0000_BEEF, 1'b0, 32'h1122_3344, 32'hBEEF_3344, 1'b0};
        vecs[3]  = '{1'b1, 2'b01, 4'b0011, 32'h010,  32'h1234_CAFE, 1'b0, 32'hBEEF_3344, 32'hBEEF_CAFE, 1'b0};
        vecs[4]  = '{1'b1, 2'b10, 4'b0011, 32'h020,  32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[5]  = '{1'b1, 2'b01, 4'b0110, 32'h020,  32'hFFFF_FFFF, 1'b1, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b0, 2'b00, 4'b0000, 32'h020,  32'h0,         1'b1, 32'h0,         32'h0,         1'b0};
        vecs[7]  = '{1'b1, 2'b00, 4'b1000, 32'h023,  32'h0000_0077, 1'b0, 32'h0,         32'h7700_0000, 1'b0};
        vecs[8]  = '{1'b1, 2'b11, 4'b1111, 32'h020,  32'hFFFF_FFFF, 1'b0, 32'h7700_0000, 32'h7700_0000, 1'b1};
        vecs[9]  = '{1'b0, 2'b11, 4'b0000, 32'h020,  32'h0,         1'b0, 32'h7700_0000, 32'h7700_0000, 1'b1};
        vecs[10] = '{1'b0, 2'b00, 4'b0000, 32'h020,  32'h0,         1'b1, 32'h7700_0000, 32'h7700_0000, 1'b0};
        vecs[11] = '{1'b1, 2'b00, 4'b0011, 32'h024,  32'h0000_0055, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[12] = '{1'b1, 2'b10, 4'b1111, 32'h1000, 32'hCAFE_F00D, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b1};
        vecs[13] = '{1'b0, 2'b00, 4'b0000, 32'h000,  32'h0,         1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};

        // Reset state and zero-fill timing
        rst_n    = 1'b0;
        dbg_addr = 32'h0;
        drive(1'b0, 2'b00, 4'b0000, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        check32("reset_init_done", {31'h0, init_done}, 32'h0);
        check32("reset_err", {31'h0, misalign_err}, 32'h0);
        check32("reset_rdata", dmem_rdata, 32'h0);
        rst_n = 1'b1;
        wait_init(cyc);
        check32("init_latency", cyc, 32'd1024);
        model_clear();
        foreach (vecs[k]) begin end
        dbg_addr = 32'h0;        #1 check32("fill_idx0", dbg_rdata, 32'h0);
        dbg_addr = 32'd511 << 2; #1 check32("fill_idx511", dbg_rdata, 32'h0);
        dbg_addr = 32'd1023 << 2; #1 check32("fill_idx1023", dbg_rdata, 32'h0);

        // Directed store vectors
        for (int k = 0; k < 14; k++) begin
            drive(vecs[k].we, vecs[k].size, vecs[k].be, vecs[k].addr, vecs[k].wdata, vecs[k].clr);
            #1 check32($sformatf("vec%0d_rd_old", k), dmem_rdata, vecs[k].exp_old);
            @(negedge clk);
            model_step(vecs[k].we, vecs[k].size, vecs[k].be, vecs[k].addr, vecs[k].wdata, vecs[k].clr);
            drive(1'b0, 2'b00, 4'b0000, 32'h0, 32'h0, 1'b0);
            dbg_addr = vecs[k].addr;
            #1 check32($sformatf("vec%0d_word", k), dbg_rdata, vecs[k].exp_word);
            check32($sformatf("vec%0d_err", k), {31'h0, misalign_err}, {31'h0, vecs[k].exp_err});
        end

        // Random traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            r_we    = ($urandom_range(0, 3) != 0);
            r_size  = 2'($urandom_range(0, 3));
            r_be    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                case (r_size)
                    2'd0:    r_be = 4'b0001 << $urandom_range(0, 3);
                    2'd1:    r_be = ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b1100;
                    default: r_be = 4'b1111;
                endcase
            end
            r_addr  = $urandom & 32'hFFFF_F07F;
            r_wdata = $urandom;
            r_clr   = ($urandom_range(0, 7) == 0);
            drive(r_we, r_size, r_be, r_addr, r_wdata, r_clr);
            dbg_addr = $urandom & 32'hFFFF_F07F;
            #1 check32("rand_rdata", dmem_rdata, model_mem[r_addr[11:2]]);
            @(negedge clk);
            model_step(r_we, r_size, r_be, r_addr, r_wdata, r_clr);
            #1 check32("rand_dbg", dbg_rdata, model_mem[dbg_addr[11:2]]);
            check32("rand_err", {31'h0, misalign_err}, {31'h0, model_err});
        end

        // Prepare a non-zero word far up the array and a raised error flag
        drive(1'b1, 2'b10, 4'b1111, 32'hFA0, 32'hA5A5_A5A5, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'b11, 4'b1111, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'b00, 4'b0000, 32'h0, 32'h0, 1'b0);
        #1 check32("pre_reset_err", {31'h0, misalign_err}, 32'h1);

        // Reset, then reset again part-way through the sweep
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check32("rst_err_cleared", {31'h0, misalign_err}, 32'h0);
        drive(1'b1, 2'b10, 4'b1111, 32'hFA0, 32'h5A5A_5A5A, 1'b0);
        dbg_addr = 32'hFA0;
        repeat (300) @(negedge clk);
        #1 check32("clear_rdata_blank", dmem_rdata, 32'h0);
        check32("clear_dbg_raw", dbg_rdata, 32'hA5A5_A5A5);
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check32("midclear_init_low", {31'h0, init_done}, 32'h0);
        rst_n = 1'b1;
        wait_init(cyc);
        drive(1'b0, 2'b00, 4'b0000, 32'h0, 32'h0, 1'b0);
        check32("reclear_latency", cyc, 32'd1024);
        model_clear();
        dbg_addr = 32'hFA0; #1 check32("clear_write_ignored", dbg_rdata, 32'h0);
        dbg_addr = 32'h0;   #1 check32("reclear_idx0", dbg_rdata, 32'h0);
        check32("reclear_err", {31'h0, misalign_err}, 32'h0);
        @(negedge clk);
        dmem_addr = 32'hFA0;
        #1 check32("ready_rdata", dmem_rdata, model_mem[1000]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
